// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART receive path: state encoding,
// default line constants and the small helpers used to derive bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int DEFAULT_CLK_FREQ  = 40_000_000;
  localparam int DEFAULT_BAUD_RATE = 9600;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Clamped so a very fast line against a slow clock still ticks every cycle
  function automatic int calc_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    int d;
    d = clk_freq / (baud_rate * oversample);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversampling tick generator: one-cycle pulse every DIV clocks while enabled.
// Kept standalone so the oversampled transmitter can reuse it.
module uart_os_tick_gen #(
  parameter int DIV = 1
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  // Disabling clears the phase so the next enable starts a fresh tick period
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else if (!en_i || cnt_q == CW'(DIV - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = en_i && (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x-oversampling UART receiver with 2-of-3 majority bit decisions, a held
// valid/ready output byte, and framing / overrun error pulses.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 en_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int M     = OVERSAMPLE / 2;
  localparam int IDX_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic                 tick;
  rx_state_t            state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d, idx_inc;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]           votes_q, votes_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 vote;
  logic                 byte_done;
  logic                 frame_bad;

  // Synchronizer resets to the idle-line level so reset never fakes a start bit
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  assign rx_s = sync_q[1];

  uart_os_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .en_i    (en_i),
    .tick_o  (tick)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      bit_cnt_q <= '0;
      votes_q   <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bit_cnt_q <= bit_cnt_d;
      votes_q   <= votes_d;
      shift_q   <= shift_d;
    end
  end

  assign idx_inc = (idx_q == IDX_W'(OVERSAMPLE - 1)) ? '0 : idx_q + 1'b1;
  assign vote    = maj3(votes_q[1], votes_q[0], rx_s);

  // Tick index 0 is the start-detection tick; every bit then spans OVERSAMPLE
  // ticks and is decided at M+1 from the two stored samples plus the live one.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bit_cnt_d = bit_cnt_q;
    votes_d   = votes_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    if (!en_i) begin
      state_d   = IDLE;
      idx_d     = '0;
      bit_cnt_d = '0;
      votes_d   = '0;
      shift_d   = '0;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d   = START;
            idx_d     = '0;
            bit_cnt_d = '0;
          end
        end
        BREAK: begin
          if (rx_s) state_d = IDLE;
        end
        default: begin
          idx_d = idx_inc;
          if (idx_inc == IDX_W'(M - 1) || idx_inc == IDX_W'(M)) begin
            votes_d = {votes_q[0], rx_s};
          end
          if (idx_inc == IDX_W'(M + 1)) begin
            case (state_q)
              START: state_d = vote ? IDLE : DATA;
              DATA: begin
                shift_d   = {vote, shift_q[DATA_BITS-1:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) state_d = STOP;
              end
              STOP: begin
                if (vote) begin
                  state_d   = IDLE;
                  byte_done = 1'b1;
                end else begin
                  state_d   = BREAK;
                  frame_bad = 1'b1;
                end
              end
              default: state_d = IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // A completed byte replaces the held one only if it is being accepted now
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= frame_bad;
      overrun_o   <= 1'b0;
      if (byte_done) begin
        if (rx_valid_o && !rx_ready_i) begin
          overrun_o <= 1'b1;
        end else begin
          rx_data_o  <= shift_q;
          rx_valid_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample at DIV=10 (160 clocks per bit);
// expected bytes go through a scoreboard queue filled as frames are sent.
module tb_uart_rx_oversample;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD_RATE  = 10_000;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int BIT_CLKS   = 160;

  logic                 wb_clk_i = 1'b0;
  logic                 wb_rst_i = 1'b1;
  logic                 en_i = 1'b1;
  logic                 rx_i = 1'b1;
  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_valid_o;
  logic                 rx_ready_i = 1'b0;
  logic                 frame_err_o;
  logic                 overrun_o;
  logic                 busy_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_oversample #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .en_i       (en_i),
    .rx_i       (rx_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(negedge wb_clk_i) begin
    if (frame_err_o) fe_cnt++;
    if (overrun_o) ov_cnt++;
  end

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_i = b;
    repeat (n) @(negedge wb_clk_i);
  endtask

  // glitch_bit >= 0 inverts that data bit for one tick period at its centre
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int glitch_bit);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < DATA_BITS; i++) begin
      if (i == glitch_bit) begin
        drive_bit(data[i], 80);
        drive_bit(~data[i], 10);
        drive_bit(data[i], BIT_CLKS - 90);
      end else begin
        drive_bit(data[i], BIT_CLKS);
      end
    end
    drive_bit(stop_bit, BIT_CLKS);
    rx_i = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_valid_o) begin
        got = 1'b1;
        break;
      end
      @(negedge wb_clk_i);
    end
  endtask

  task automatic accept();
    rx_ready_i = 1'b1;
    @(negedge wb_clk_i);
    rx_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    n_cmp++;
    if (rx_data_o !== 8'h00) begin
      n_fail++; $display("[TB] FAIL reset_data got=%h exp=00", rx_data_o);
    end
    n_cmp++;
    if ({rx_valid_o, frame_err_o, overrun_o, busy_o} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags got=%b exp=0000",
               {rx_valid_o, frame_err_o, overrun_o, busy_o});
    end
    wb_rst_i = 1'b0;
    idle(20);
  endtask

  task automatic test_basic();
    bit got, held_ok;
    logic [7:0] exp;
    int fe0 = fe_cnt, ov0 = ov_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    wait_valid(400, got);
    n_cmp++;
    if (!got) begin
      n_fail++; $display("[TB] FAIL basic_valid got=0 exp=1");
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (rx_data_o !== exp) begin
      n_fail++; $display("[TB] FAIL basic_data got=%h exp=%h", rx_data_o, exp);
    end
    held_ok = 1'b1;
    repeat (500) begin
      @(negedge wb_clk_i);
      if (rx_valid_o !== 1'b1 || rx_data_o !== exp) held_ok = 1'b0;
    end
    n_cmp++;
    if (!held_ok) begin
      n_fail++; $display("[TB] FAIL basic_hold got=0 exp=1");
    end
    accept();
    n_cmp++;
    if (rx_valid_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL basic_accept got=%b exp=0", rx_valid_o);
    end
    n_cmp++;
    if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin
      n_fail++;
      $display("[TB] FAIL basic_errs got=fe%0d/ov%0d exp=fe0/ov0",
               fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_false_start();
    bit went_idle;
    int fe0 = fe_cnt;
    drive_bit(1'b0, 50);
    rx_i = 1'b1;
    went_idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge wb_clk_i);
      if (!busy_o) begin
        went_idle = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!went_idle) begin
      n_fail++; $display("[TB] FAIL false_start_busy got=1 exp=0");
    end
    idle(200);
    n_cmp++;
    if (rx_valid_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL false_start_valid got=%b exp=0", rx_valid_o);
    end
    n_cmp++;
    if (fe_cnt != fe0) begin
      n_fail++; $display("[TB] FAIL false_start_err got=%0d exp=0", fe_cnt - fe0);
    end
  endtask

  task automatic test_frame_error();
    bit got;
    logic [7:0] exp;
    int fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1);
    idle(320);
    n_cmp++;
    if (fe_cnt - fe0 != 1) begin
      n_fail++; $display("[TB] FAIL frame_err_pulses got=%0d exp=1", fe_cnt - fe0);
    end
    n_cmp++;
    if (rx_valid_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL frame_err_valid got=%b exp=0", rx_valid_o);
    end
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, -1);
    wait_valid(400, got);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got || rx_data_o !== exp) begin
      n_fail++;
      $display("[TB] FAIL frame_err_recover got=%b/%h exp=1/%h", got, rx_data_o, exp);
    end
    accept();
  endtask

  task automatic test_overrun();
    bit got;
    logic [7:0] exp;
    int ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    idle(40);
    n_cmp++;
    if (ov_cnt - ov0 != 1) begin
      n_fail++; $display("[TB] FAIL overrun_pulses got=%0d exp=1", ov_cnt - ov0);
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== exp) begin
      n_fail++;
      $display("[TB] FAIL overrun_kept got=%b/%h exp=1/%h", rx_valid_o, rx_data_o, exp);
    end
    accept();
    n_cmp++;
    if (rx_valid_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL overrun_accept got=%b exp=0", rx_valid_o);
    end
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1, -1);
    wait_valid(400, got);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got || rx_data_o !== exp) begin
      n_fail++;
      $display("[TB] FAIL overrun_next got=%b/%h exp=1/%h", got, rx_data_o, exp);
    end
    n_cmp++;
    if (ov_cnt - ov0 != 1) begin
      n_fail++; $display("[TB] FAIL overrun_extra got=%0d exp=1", ov_cnt - ov0);
    end
    accept();
  endtask

  task automatic test_glitch();
    bit got;
    logic [7:0] exp;
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, 3);
    wait_valid(400, got);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got || rx_data_o !== exp) begin
      n_fail++;
      $display("[TB] FAIL glitch_reject got=%b/%h exp=1/%h", got, rx_data_o, exp);
    end
    accept();
  endtask

  task automatic test_reset_mid_frame();
    bit got;
    logic [7:0] exp;
    logic [7:0] stream [3] = '{8'h12, 8'h34, 8'h56};
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(stream[k]);
      send_frame(stream[k], 1'b1, -1);
      wait_valid(400, got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!got || rx_data_o !== exp) begin
        n_fail++;
        $display("[TB] FAIL stream_byte%0d got=%b/%h exp=1/%h", k, got, rx_data_o, exp);
      end
      if (k < 2) accept();
    end
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(i[0], BIT_CLKS);
    drive_bit(1'b1, 80);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    n_cmp++;
    if ({rx_data_o, rx_valid_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs got=%h/%b%b%b%b exp=00/0000",
               rx_data_o, rx_valid_o, frame_err_o, overrun_o, busy_o);
    end
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    idle(400);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1);
    wait_valid(400, got);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got || rx_data_o !== exp) begin
      n_fail++;
      $display("[TB] FAIL midreset_recover got=%b/%h exp=1/%h", got, rx_data_o, exp);
    end
    accept();
  endtask

  task automatic test_enable_drop();
    bit got, went_idle;
    logic [7:0] exp;
    int fe0 = fe_cnt;
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS);
    drive_bit(1'b0, 80);
    en_i = 1'b0;
    went_idle = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge wb_clk_i);
      if (!busy_o) begin
        went_idle = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!went_idle) begin
      n_fail++; $display("[TB] FAIL en_drop_busy got=1 exp=0");
    end
    idle(BIT_CLKS * 8);
    en_i = 1'b1;
    idle(320);
    n_cmp++;
    if (fe_cnt != fe0 || rx_valid_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL en_drop_quiet got=fe%0d/v%b exp=fe0/v0", fe_cnt - fe0, rx_valid_o);
    end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1);
    wait_valid(400, got);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got || rx_data_o !== exp) begin
      n_fail++;
      $display("[TB] FAIL en_drop_recover got=%b/%h exp=1/%h", got, rx_data_o, exp);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_error();
    test_overrun();
    test_glitch();
    test_reset_mid_frame();
    test_enable_drop();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("[TB] FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
